cpu6_memresp: RTL and testbench

Memory responder on the far side of the cpu6 core's instruction-fetch and data-memory ports. It holds a word-addressed unified RAM, returns instructions for `pcF` and load data for `dataaddr`, and commits stores. It also maps a tohost mailbox for test termination. A boot-loader FSM streams a program image into RAM while holding the core in reset, then releases it.

---
 rtl/cpu6_memresp_pkg.sv | 23 ++
 rtl/cpu6_memresp_ram.sv | 32 +++
 rtl/cpu6_memresp.sv | 144 ++++++++++++++
 tb/tb_cpu6_memresp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu6_memresp_pkg.sv
// Shared types and constants for the cpu6 memory responder.
// CPU6_XLEN mirrors the core-wide datapath width.
package cpu6_memresp_pkg;

  localparam int unsigned CPU6_XLEN = 32;

  localparam logic [CPU6_XLEN-1:0] CPU6_NOP_INSTR    = 32'h0000_0013;
  localparam logic [CPU6_XLEN-1:0] CPU6_TOHOST_ADDR  = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  // Selects what the registered fetch output presents.
  typedef enum logic [1:0] {
    FETCH_NOP  = 2'd0,
    FETCH_ZERO = 2'd1,
    FETCH_RAM  = 2'd2
  } fetch_sel_e;

endpackage

// File: rtl/cpu6_memresp_ram.sv
// Unified word RAM: synchronous fetch port, asynchronous data port, one write port.
// Fetch is read-before-write for a same-word store in the same cycle.
module cpu6_memresp_ram
  import cpu6_memresp_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [CPU6_XLEN-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr_f,
  output logic [CPU6_XLEN-1:0] o_rdata_f,
  input  logic [AW-1:0]        i_raddr_d,
  output logic [CPU6_XLEN-1:0] o_rdata_d
);

  logic [CPU6_XLEN-1:0] r_mem [DEPTH];
  logic [CPU6_XLEN-1:0] r_rdata_f;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata_f <= r_mem[i_raddr_f];
  end

  assign o_rdata_f = r_rdata_f;
  assign o_rdata_d = r_mem[i_raddr_d];

endmodule

// File: rtl/cpu6_memresp.sv
// Memory responder for the cpu6 core: boot loader, fetch/load/store service and
// a tohost mailbox that halts the core when written.
module cpu6_memresp
  import cpu6_memresp_pkg::*;
#(
  parameter int unsigned          DEPTH       = 1024,
  parameter logic [CPU6_XLEN-1:0] TOHOST_ADDR = CPU6_TOHOST_ADDR,
  parameter logic [CPU6_XLEN-1:0] NOP_INSTR   = CPU6_NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CPU6_XLEN-1:0] pcF,
  output logic [CPU6_XLEN-1:0] instr,
  input  logic                 memwriteM,
  input  logic [CPU6_XLEN-1:0] dataaddr,
  input  logic [CPU6_XLEN-1:0] writedata,
  output logic [CPU6_XLEN-1:0] readdata,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [CPU6_XLEN-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 core_reset,
  output logic [CPU6_XLEN-1:0] tohost,
  output logic                 tohost_valid,
  output logic                 load_err,
  output logic                 misalign_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  state_e               r_state, w_state_next;
  fetch_sel_e           r_fetch_sel;
  logic [AW-1:0]        r_ld_ptr;
  logic                 r_core_reset;
  logic [CPU6_XLEN-1:0] r_tohost;
  logic                 r_tohost_valid, r_load_err, r_misalign_err;

  logic                 w_beat, w_store, w_misalign, w_st_tohost, w_st_ram;
  logic                 w_d_in_span, w_d_tohost, w_f_in_span;
  logic                 w_we;
  logic [AW-1:0]        w_waddr;
  logic [CPU6_XLEN-1:0] w_wdata, w_rdata_f, w_rdata_d;

  assign w_beat      = (r_state == S_LOAD) && ld_valid;
  assign w_f_in_span = (pcF[CPU6_XLEN-1:AW+2] == '0);
  assign w_d_in_span = (dataaddr[CPU6_XLEN-1:AW+2] == '0);
  assign w_d_tohost  = (dataaddr[CPU6_XLEN-1:2] == TOHOST_ADDR[CPU6_XLEN-1:2]);

  // Misaligned stores are dropped before any address decode, including tohost.
  assign w_misalign  = (r_state == S_RUN) && memwriteM && (dataaddr[1:0] != 2'b00);
  assign w_store     = (r_state == S_RUN) && memwriteM && (dataaddr[1:0] == 2'b00);
  assign w_st_tohost = w_store && (dataaddr == TOHOST_ADDR);
  assign w_st_ram    = w_store && w_d_in_span;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_LOAD:  if (w_beat && ld_last) w_state_next = S_RUN;
      S_RUN:   if (w_st_tohost) w_state_next = S_HALT;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_LOAD;
      r_core_reset   <= 1'b1;
      r_fetch_sel    <= FETCH_NOP;
      r_ld_ptr       <= '0;
      r_tohost       <= '0;
      r_tohost_valid <= 1'b0;
      r_load_err     <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_core_reset <= (w_state_next != S_RUN);
      if (r_state != S_RUN)  r_fetch_sel <= FETCH_NOP;
      else if (!w_f_in_span) r_fetch_sel <= FETCH_ZERO;
      else                   r_fetch_sel <= FETCH_RAM;
      if (w_beat) begin
        r_ld_ptr <= r_ld_ptr + 1'b1;
        if (!ld_last && (r_ld_ptr == LastPtr)) r_load_err <= 1'b1;
      end
      if (w_misalign) r_misalign_err <= 1'b1;
      if (w_st_tohost) begin
        r_tohost       <= writedata;
        r_tohost_valid <= 1'b1;
      end
    end
  end

  // The single write port belongs to the loader while loading, to the core otherwise.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = dataaddr[AW+1:2];
    w_wdata = writedata;
    if (r_state == S_LOAD) begin
      w_we    = ld_valid;
      w_waddr = r_ld_ptr;
      w_wdata = ld_data;
    end else begin
      w_we    = w_st_ram;
    end
  end

  cpu6_memresp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_f (pcF[AW+1:2]),
    .o_rdata_f (w_rdata_f),
    .i_raddr_d (dataaddr[AW+1:2]),
    .o_rdata_d (w_rdata_d)
  );

  always_comb begin
    instr = NOP_INSTR;
    unique case (r_fetch_sel)
      FETCH_ZERO: instr = '0;
      FETCH_RAM:  instr = w_rdata_f;
      default:    instr = NOP_INSTR;
    endcase
  end

  always_comb begin
    readdata = '0;
    if (w_d_in_span)     readdata = w_rdata_d;
    else if (w_d_tohost) readdata = r_tohost;
  end

  assign ld_ready     = (r_state == S_LOAD);
  assign core_reset   = r_core_reset;
  assign tohost       = r_tohost;
  assign tohost_valid = r_tohost_valid;
  assign load_err     = r_load_err;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_cpu6_memresp.sv
// Directed self-checking bench for cpu6_memresp with a small RAM (DEPTH = 16).
module tb_cpu6_memresp;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] TOHOST = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk, reset;
  logic [31:0] pcF, instr, dataaddr, writedata, readdata, ld_data, tohost;
  logic        memwriteM, ld_valid, ld_ready, ld_last, core_reset;
  logic        tohost_valid, load_err, misalign_err;

  int n_vec = 0;
  int n_err = 0;

  cpu6_memresp #(
    .DEPTH       (DEPTH),
    .TOHOST_ADDR (TOHOST),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pcF          (pcF),
    .instr        (instr),
    .memwriteM    (memwriteM),
    .dataaddr     (dataaddr),
    .writedata    (writedata),
    .readdata     (readdata),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .core_reset   (core_reset),
    .tohost       (tohost),
    .tohost_valid (tohost_valid),
    .load_err     (load_err),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    memwriteM = 1'b1;
    dataaddr  = addr;
    writedata = data;
    cyc();
    memwriteM = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    dataaddr = addr;
    #1;
    check_val(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; pcF = '0; memwriteM = 1'b0; dataaddr = '0; writedata = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #2;
    check_val("rst_instr", instr, NOP);
    check_val("rst_core_reset", {31'b0, core_reset}, 32'd1);
    check_val("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    check_val("rst_tohost", tohost, 32'd0);
    check_val("rst_tohost_valid", {31'b0, tohost_valid}, 32'd0);
    check_val("rst_load_err", {31'b0, load_err}, 32'd0);
    check_val("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
    cyc();
    reset = 1'b0;

    // Boot image of three words.
    beat(32'h0000_0013, 1'b0);
    beat(32'h0010_0093, 1'b0);
    check_val("core_reset_pre_last", {31'b0, core_reset}, 32'd1);
    beat(32'h0020_0113, 1'b1);
    check_val("core_reset_after_last", {31'b0, core_reset}, 32'd0);
    check_val("ld_ready_run", {31'b0, ld_ready}, 32'd0);
    check_val("instr_at_last_edge", instr, NOP);
    pcF = 32'h4;
    cyc();
    check_val("first_fetch", instr, 32'h0010_0093);
    rd_check("load_w1", 32'h4, 32'h0010_0093);

    // Store/fetch ordering on word 4.
    store(32'h10, 32'h1111_1111);
    pcF = 32'h10;
    store(32'h10, 32'hDEAD_BEEF);
    check_val("fetch_old_word", instr, 32'h1111_1111);
    rd_check("load_after_store", 32'h10, 32'hDEAD_BEEF);
    cyc();
    check_val("fetch_new_word", instr, 32'hDEAD_BEEF);

    // Beyond the RAM span.
    pcF = 32'h40;
    cyc();
    check_val("fetch_out_of_span", instr, 32'd0);
    rd_check("load_out_of_span", 32'h40, 32'd0);
    store(32'h40, 32'h5555_5555);
    rd_check("oos_store_no_alias", 32'h0, 32'h0000_0013);

    // Misaligned store.
    store(32'h6, 32'hCAFE_F00D);
    check_val("misalign_set", {31'b0, misalign_err}, 32'd1);
    rd_check("misalign_w1_kept", 32'h4, 32'h0010_0093);
    cyc();
    check_val("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Tohost store halts the core.
    store(TOHOST, 32'h1);
    check_val("tohost_val", tohost, 32'h1);
    check_val("tohost_valid", {31'b0, tohost_valid}, 32'd1);
    check_val("halt_core_reset", {31'b0, core_reset}, 32'd1);
    rd_check("load_tohost", TOHOST, 32'h1);
    store(32'h0, 32'hFFFF_FFFF);
    store(TOHOST, 32'h5);
    rd_check("halt_store_dropped", 32'h0, 32'h0000_0013);
    check_val("tohost_held", tohost, 32'h1);
    check_val("halt_instr_nop", instr, NOP);
    check_val("halt_ld_ready", {31'b0, ld_ready}, 32'd0);

    // Reset, then overflow the loader pointer.
    reset = 1'b1;
    #1;
    check_val("rst2_misalign", {31'b0, misalign_err}, 32'd0);
    check_val("rst2_tohost_valid", {31'b0, tohost_valid}, 32'd0);
    check_val("rst2_ld_ready", {31'b0, ld_ready}, 32'd1);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      beat(32'hA0 + 32'(i), 1'b0);
      if (i == 5) cyc();
    end
    check_val("load_err_before_wrap", {31'b0, load_err}, 32'd0);
    beat(32'hAF, 1'b0);
    check_val("load_err_at_wrap", {31'b0, load_err}, 32'd1);
    beat(32'hB0, 1'b0);
    check_val("core_reset_while_loading", {31'b0, core_reset}, 32'd1);
    beat(32'hCC, 1'b1);
    check_val("wrap_run", {31'b0, core_reset}, 32'd0);
    rd_check("wrap_w0", 32'h0, 32'hB0);
    rd_check("wrap_w1", 32'h4, 32'hCC);
    rd_check("wrap_w2", 32'h8, 32'hA2);
    rd_check("wrap_w6", 32'h18, 32'hA6);
    check_val("load_err_sticky", {31'b0, load_err}, 32'd1);

    // Async reset mid-run, then reset mid-load.
    #2;
    reset = 1'b1;
    #1;
    check_val("async_core_reset", {31'b0, core_reset}, 32'd1);
    check_val("async_load_err", {31'b0, load_err}, 32'd0);
    cyc();
    reset = 1'b0;
    beat(32'h1111_0000, 1'b0);
    beat(32'h1111_0001, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_val("midload_ld_ready", {31'b0, ld_ready}, 32'd1);
    check_val("midload_core_reset", {31'b0, core_reset}, 32'd1);
    cyc();
    reset = 1'b0;
    beat(32'h0000_2222, 1'b1);
    check_val("reload_run", {31'b0, core_reset}, 32'd0);
    rd_check("reload_w0", 32'h0, 32'h0000_2222);
    rd_check("reload_w1_kept", 32'h4, 32'h1111_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
